// File: rtl/digit_reduce_pkg.sv
// Shared encodings and sizing helper for the digit reduction engine.
// The result width is derived here so that the engine and the lane reducer agree on it.
package digit_reduce_pkg;

    localparam logic [1:0] MODE_SUM   = 2'b00;
    localparam logic [1:0] MODE_NZCNT = 2'b01;
    localparam logic [1:0] MODE_MAX   = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Smallest width that holds the sum of every digit at its maximum value.
    function automatic int calc_sum_w(input int data_w, input int digit_w);
        return $clog2((data_w / digit_w) * ((1 << digit_w) - 1) + 1);
    endfunction

endpackage

// File: rtl/digit_lane_reduce.sv
// Combinational merge of LANES digits into the running accumulator for the selected mode.
// Digits are zero-extended to SUM_W; the reserved mode code behaves as SUM.
module digit_lane_reduce
    import digit_reduce_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int DIGIT_W = 4,
    parameter int SUM_W   = 7
) (
    input  logic [LANES*DIGIT_W-1:0] digits,
    input  logic [1:0]               mode,
    input  logic [SUM_W-1:0]         acc,
    output logic [SUM_W-1:0]         acc_next
);

    logic [SUM_W-1:0] dig;

    always_comb begin
        acc_next = acc;
        dig      = '0;
        for (int i = 0; i < LANES; i++) begin
            dig = SUM_W'(digits[i*DIGIT_W +: DIGIT_W]);
            case (mode)
                MODE_NZCNT: begin
                    if (dig != '0) acc_next = acc_next + SUM_W'(1);
                end
                MODE_MAX: begin
                    if (dig > acc_next) acc_next = dig;
                end
                default: acc_next = acc_next + dig;
            endcase
        end
    end

endmodule

// File: rtl/digit_reduce_engine.sv
// Serial digit reducer (sum / nonzero count / max), LANES digits per clock, start/busy/done handshake.
// Define DIGIT_REDUCE_EARLY_EXIT_EN to finish as soon as the remaining digits are all zero.
module digit_reduce_engine
    import digit_reduce_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  DIGIT_W = 4,
    parameter int  LANES   = 1,
    localparam int SUM_W   = calc_sum_w(DATA_W, DIGIT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] num,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  result
);

    localparam int NDIG   = DATA_W / DIGIT_W;
    localparam int NSTEP  = NDIG / LANES;
    localparam int SHIFT  = LANES * DIGIT_W;
    localparam int STEP_W = $clog2(NSTEP + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic [1:0]        mode_q;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  acc_next;
    logic [STEP_W-1:0] step;
    logic              accept;
    logic              finish;

    digit_lane_reduce #(
        .LANES   (LANES),
        .DIGIT_W (DIGIT_W),
        .SUM_W   (SUM_W)
    ) u_lane (
        .digits   (shreg[SHIFT-1:0]),
        .mode     (mode_q),
        .acc      (acc),
        .acc_next (acc_next)
    );

    assign sh_next = shreg >> SHIFT;
    assign accept  = start && (state != ST_RUN);
    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);

`ifdef DIGIT_REDUCE_EARLY_EXIT_EN
    // Remaining digits are all zero: they cannot change any mode's result.
    assign finish = (step == LAST_STEP) || (sh_next == '0);
`else
    assign finish = (step == LAST_STEP);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            mode_q <= MODE_SUM;
            acc    <= '0;
            step   <= '0;
            result <= '0;
        end else if (accept) begin
            state  <= ST_RUN;
            shreg  <= num;
            mode_q <= mode;
            acc    <= '0;
            step   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc   <= acc_next;
                    shreg <= sh_next;
                    step  <= step + STEP_W'(1);
                    if (finish) begin
                        state  <= ST_DONE;
                        result <= acc_next;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_reduce_engine.sv
// Randomized and directed check of digit_reduce_engine against a digit-level arithmetic model.
// Honours DIGIT_REDUCE_EARLY_EXIT_EN for expected latency; LANES selects the lane build.
module tb_digit_reduce_engine;

    parameter int LANES = 1;
    localparam int DATA_W  = 32;
    localparam int DIGIT_W = 4;
    localparam int NDIG    = DATA_W / DIGIT_W;
    localparam int NSTEP   = NDIG / LANES;
    localparam int SUM_W   = $clog2(NDIG * 15 + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [DATA_W-1:0] num = '0;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  result;

    int vectors = 0;
    int miscompares = 0;
    logic [SUM_W-1:0] last_res = '0;

    digit_reduce_engine #(
        .DATA_W  (DATA_W),
        .DIGIT_W (DIGIT_W),
        .LANES   (LANES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .num    (num),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] ref_reduce(input logic [31:0] n, input logic [1:0] m);
        int s = 0;
        int c = 0;
        int mx = 0;
        for (int i = 0; i < NDIG; i++) begin
            int d;
            d = int'((n >> (DIGIT_W * i)) & 32'hF);
            s += d;
            if (d != 0) c++;
            if (d > mx) mx = d;
        end
        case (m)
            2'b01:   return SUM_W'(c);
            2'b10:   return SUM_W'(mx);
            default: return SUM_W'(s);
        endcase
    endfunction

    function automatic int exp_lat(input logic [31:0] n);
`ifdef DIGIT_REDUCE_EARLY_EXIT_EN
        int h = 0;
        for (int i = 0; i < NDIG; i++)
            if (((n >> (DIGIT_W * i)) & 32'hF) != 0) h = i;
        return h / LANES + 1;
`else
        return (n == n) ? NSTEP : NSTEP;
`endif
    endfunction

    // Entered #1 after a rising edge; start drives the next edge.
    task automatic run_job(input logic [31:0] n, input logic [1:0] m, input bit poke);
        int lat;
        int k;
        bit seen;
        logic [SUM_W-1:0] r;
        lat  = exp_lat(n);
        r    = ref_reduce(n, m);
        seen = 0;
        chk("result_held", result, last_res);
        start = 1'b1;
        num   = n;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        num   = $urandom;
        mode  = 2'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("done_after_accept", done, 0);
        for (k = 1; k <= NSTEP + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
            chk("busy_run", busy, 1);
            if (poke && k == 1) begin
                start = 1'b1;
                num   = $urandom;
                mode  = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("latency", k, lat);
            chk("busy_at_done", busy, 0);
            chk("result", result, r);
        end
        last_res = r;
    endtask

    task automatic idle(input int g);
        if (g > 0) begin
            @(posedge clk); #1;
            chk("done_one_cycle", done, 0);
            chk("busy_idle", busy, 0);
            repeat (g - 1) @(posedge clk);
            if (g > 1) #1;
        end
    endtask

    initial begin
        int dones;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(32'h12345678, 2'b00, 1'b0);
        chk("sum_12345678", result, 36);
        idle(1);
        run_job(32'hFFFFFFFF, 2'b00, 1'b0);
        chk("sum_ffffffff", result, 120);
        run_job(32'h10203000, 2'b01, 1'b0);
        chk("nz_10203000", result, 3);
        idle(2);
        run_job(32'h1A2B3C4D, 2'b10, 1'b0);
        chk("max_1a2b3c4d", result, 13);
        run_job(32'h00000000, 2'b10, 1'b0);
        chk("max_zero", result, 0);
        idle(1);
        run_job(32'h00000012, 2'b00, 1'b0);
        chk("sum_12", result, 3);
        idle(1);
        run_job(32'h12345678, 2'b00, 1'b1);
        chk("poke_ignored", result, 36);
        idle(3);

        // Abort mid-job: no done may follow.
        start = 1'b1;
        num   = 32'h87654321;
        mode  = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (NSTEP + 4) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("no_done_after_abort", dones, 0);
        last_res = '0;
        run_job(32'h13572468, 2'b00, 1'b0);

        for (int j = 0; j < 40; j++) begin
            logic [31:0] n;
            n = $urandom;
            for (int d = 0; d < NDIG; d++)
                if ($urandom_range(0, 2) == 0) n[d*DIGIT_W +: DIGIT_W] = '0;
            if ($urandom_range(0, 4) == 0) n = n & 32'h0000_0FFF;
            run_job(n, 2'($urandom), bit'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digit_reduce_engine.md
Name: digit_reduce_engine

Overview:
- Multi-cycle serial reducer over the digits of a DATA_W-bit word. Each word is split into NDIG = DATA_W/DIGIT_W digits, consumed LSB-digit first, LANES digits per clock.
- Three reduction modes: digit sum, nonzero-digit count, maximum digit.
- Start/busy/done handshake, so a controller or testbench issues back-to-back jobs without pulsing reset per word.
- Sits between a register-file/operand source and a result register in the lab datapath.

Parameters:
- DATA_W, 32: input word width; must be a multiple of DIGIT_W.
- DIGIT_W, 4: digit width in bits (4 = hex, 3 = octal, 1 = popcount).
- LANES, 1: digits reduced per cycle; must divide NDIG.
- SUM_W (localparam): clog2(NDIG*(2^DIGIT_W-1)+1). Equals 7 for the defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled at rising edge.
- mode  in  2  00 SUM, 01 NZCNT, 10 MAX, 11 reserved (behaves as SUM).
- num  in  DATA_W  operand.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  SUM_W  reduction result; held until next accepted start.

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - On reset: state=IDLE, busy=0, done=0, result=0, shift register=0, step counter=0, accumulator=0.
  - Reset asserted mid-job aborts the job; no done pulse is produced.
- States:
  - IDLE: wait for start.
  - RUN: reduce digits.
  - DONE: one cycle, then IDLE.
- Accept: start=1 at an edge in IDLE or DONE.
  - Captures num into the shift register and mode into a mode register.
  - Clears accumulator and step counter; next state RUN.
  - start in RUN is ignored; num/mode changes during RUN have no effect.
- RUN, each edge:
  - The low LANES digits of the shift register are reduced and merged into the accumulator:
    - SUM adds all digits.
    - NZCNT adds the count of digits != 0.
    - MAX keeps max(acc, max digit).
  - Shift register shifts right by LANES*DIGIT_W, zero-fill.
  - Step counter increments.
  - After NSTEP = NDIG/LANES RUN edges, next state is DONE and result is loaded with the final accumulator value.
- Latency: start accepted at edge 0 → busy=1 after edge 0 through edge NSTEP-1; done=1 and result valid after edge NSTEP, for exactly one cycle. Defaults give NSTEP=8.
- Back-to-back: start=1 during DONE is accepted at that edge; done deasserts and busy reasserts on the same edge. Zero idle cycles between jobs.
- Width: all accumulation is in SUM_W bits, zero-extended digits. No overflow is possible by construction of SUM_W. MAX and NZCNT results are zero-extended.
- busy and done are never high simultaneously.

Optional Feature:
- Macro DIGIT_REDUCE_EARLY_EXIT_EN.
- Defined: in RUN, if the post-shift value of the shift register is zero, the next state is DONE immediately, after at least one RUN edge. Latency is then ceil(index of highest nonzero digit group + 1), minimum 1. Results are identical to the non-early-exit case for all modes: remaining zero digits add nothing to SUM or NZCNT and cannot raise MAX.
- Undefined: fixed latency NSTEP for every operand.

Decomposition:
- Package digit_reduce_pkg:
  - mode encodings MODE_SUM/MODE_NZCNT/MODE_MAX;
  - state enum IDLE/RUN/DONE;
  - function computing SUM_W from DATA_W, DIGIT_W.
- Sub-module digit_lane_reduce:
  - combinational, parameter LANES, DIGIT_W, SUM_W;
  - inputs: LANES digits, mode, accumulator;
  - output: next accumulator.
  - Instantiated once in the top; holds all mode arithmetic.
- Top holds only the FSM, counters and registers.

Test Plan:
- Defaults, num=32'h12345678, mode SUM → busy for 8 cycles, done pulse after edge 8, result=36 (7'h24).
- num=32'hFFFFFFFF SUM → result=120. Then back-to-back start in the DONE cycle with num=32'h10203000, NZCNT → second done 8 edges later, result=3.
- num=32'h1A2B3C4D, MAX → result=13. Also num=0, MAX → result=0.
- LANES=2 build, num=32'h12345678 SUM → done after edge 4, result=36. Also start pulsed while busy → ignored; result unchanged from the first job.
- rst asserted at RUN step 3 → busy=0, done=0, result=0 immediately. No done pulse follows; next start runs a full job correctly.
- num=32'h00000012 SUM → result=3:
  - with DIGIT_REDUCE_EARLY_EXIT_EN, done after edge 2;
  - without it, done after edge 8.
